// File: rtl/rect_fill_gen_engine_if.sv
// -----------------------------------------------------------------------------
// rect_fill_gen_engine_if
//
// Write-port bundle between the rectangle fill generator and the arbiter.
//   arb_out_rts   : write valid (generator -> arbiter)
//   arb_in_rtr    : arbiter ready (arbiter -> generator)
//   arb_out_wben  : per-byte-lane write enables
//   arb_out_addr  : word address
//   arb_out_data  : write data
//   arb_out_op    : 1 = write
// A transfer happens on a clock edge where arb_out_rts & arb_in_rtr.
// -----------------------------------------------------------------------------
interface rect_fill_gen_engine_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  arb_out_rts;
    logic                  arb_in_rtr;
    logic [DATA_W/8-1:0]   arb_out_wben;
    logic [ADDR_W-1:0]     arb_out_addr;
    logic [DATA_W-1:0]     arb_out_data;
    logic                  arb_out_op;

    modport master (
        output arb_out_rts,
        input  arb_in_rtr,
        output arb_out_wben,
        output arb_out_addr,
        output arb_out_data,
        output arb_out_op
    );

    modport slave (
        input  arb_out_rts,
        output arb_in_rtr,
        input  arb_out_wben,
        input  arb_out_addr,
        input  arb_out_data,
        input  arb_out_op
    );
endinterface

// File: rtl/rect_fill_gen_engine.sv
// -----------------------------------------------------------------------------
// rect_fill_gen_engine
//
// Rectangle fill data generator. On a start strobe it walks the rectangle
// row by row, word by word, channel by channel, issuing one arbiter write per
// (word, channel). Pixels sharing a frame-buffer word are coalesced into one
// write with per-pixel byte enables. Solid and outline-only modes.
//
// Ports:
//   clk, rst_            clock, asynchronous active-low reset
//   gen_start_strobe     start request, sampled only while idle
//   init_addr/init_lane  word address / byte lane of the first pixel
//   cmd_data_hgt/_wid    rectangle size in rows / pixels
//   cmd_data_color       channel ch in bits [8ch+7:8ch]
//   cmd_mode             0 = solid, 1 = outline only
//   data_gen_is_idle     high while idle
//   gen_done             one-cycle pulse when a command finishes
//   arb                  write port (rect_fill_gen_engine_if.master)
//   xfer_cnt             saturating transfer count (only with
//                        RECT_GEN_XFER_CNT_EN defined)
//
// Optional feature macro: RECT_GEN_XFER_CNT_EN
// -----------------------------------------------------------------------------
module rect_fill_gen_engine #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 3,
    parameter int ROW_STRIDE = 240,
    parameter int LANE_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  gen_start_strobe,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic [LANE_W-1:0]     init_lane,
    input  logic [15:0]           cmd_data_hgt,
    input  logic [15:0]           cmd_data_wid,
    input  logic [NUM_CH*8-1:0]   cmd_data_color,
    input  logic                  cmd_mode,
    output logic                  data_gen_is_idle,
    output logic                  gen_done,
    rect_fill_gen_engine_if.master arb
`ifdef RECT_GEN_XFER_CNT_EN
    ,
    output logic [31:0]           xfer_cnt
`endif
);

    localparam int PIX    = DATA_W / 8;
    localparam int PIX_SH = $clog2(PIX);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        DONE
    } state_t;

    state_t              state;

    // Latched command
    logic [15:0]         hgt_q;
    logic [15:0]         wid_q;
    logic [LANE_W-1:0]   lane_q;
    logic [NUM_CH*8-1:0] color_q;
    logic                outline_q;   // outline mode that does not degenerate to solid
    logic [16:0]         nw_q;        // words per row

    // Position of the write currently presented
    logic [15:0]         row_q;
    logic [16:0]         word_q;
    logic [CH_W-1:0]     ch_q;
    logic [ADDR_W-1:0]   row_base_q;

    logic                xfc;

    // Byte enables for one word: lane k holds column word*PIX + k - lane.
    // Interior outline rows keep only the first and last column.
    function automatic logic [PIX-1:0] calc_wben(
        input logic [16:0]       word,
        input logic [LANE_W-1:0] lane,
        input logic [15:0]       wid,
        input logic              interior
    );
        logic [PIX-1:0] en;
        int             c;
        int             last_c;
        en     = '0;
        last_c = int'(wid) - 1;
        for (int k = 0; k < PIX; k++) begin
            c = int'(word) * PIX + k - int'(lane);
            if (interior) en[k] = (c == 0) || (c == last_c);
            else          en[k] = (c >= 0) && (c <= last_c);
        end
        return en;
    endfunction

    // Colour byte of one channel replicated into every byte lane.
    function automatic logic [DATA_W-1:0] lane_data(
        input logic [NUM_CH*8-1:0] color,
        input logic [CH_W-1:0]     ch
    );
        return {PIX{color[32'(ch)*8 +: 8]}};
    endfunction

    // Values captured on an accepted start
    logic [16:0] start_nw;
    logic        start_outline;
    logic        start_empty;

    assign start_nw      = 17'((17'(init_lane) + 17'(cmd_data_wid) + 17'(PIX - 1)) >> PIX_SH);
    assign start_outline = cmd_mode && (cmd_data_wid != 16'd1) && (cmd_data_hgt > 16'd2);
    assign start_empty   = (cmd_data_hgt == 16'd0) || (cmd_data_wid == 16'd0);

    assign xfc              = arb.arb_out_rts && arb.arb_in_rtr;
    assign data_gen_is_idle = (state == IDLE);

    // Next write position after the current one transfers
    logic [CH_W-1:0]   nxt_ch;
    logic [16:0]       nxt_word;
    logic [15:0]       nxt_row;
    logic [ADDR_W-1:0] nxt_row_base;
    logic              nxt_last;
    logic              cur_interior;
    logic              nxt_interior;
    logic [ADDR_W-1:0] nxt_addr;

    assign cur_interior = outline_q && (row_q != 16'd0) && (row_q != hgt_q - 16'd1);
    assign nxt_interior = outline_q && (nxt_row != 16'd0) && (nxt_row != hgt_q - 16'd1);
    assign nxt_addr     = nxt_row_base + ADDR_W'(int'(nxt_word) * NUM_CH) + ADDR_W'(nxt_ch);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nxt_ch       = ch_q;
        nxt_word     = word_q;
        nxt_row      = row_q;
        nxt_row_base = row_base_q;
        nxt_last     = 1'b0;
        if (ch_q != CH_W'(NUM_CH - 1)) begin
            nxt_ch = ch_q + 1'b1;
        end else begin
            nxt_ch = '0;
            if (word_q != nw_q - 17'd1) begin
                // Interior outline rows: middle words are all-zero, jump to the last
                if (cur_interior && (word_q == 17'd0)) nxt_word = nw_q - 17'd1;
                else                                   nxt_word = word_q + 17'd1;
            end else if (row_q != hgt_q - 16'd1) begin
                nxt_word     = '0;
                nxt_row      = row_q + 16'd1;
                nxt_row_base = row_base_q + ADDR_W'(ROW_STRIDE);
            end else begin
                nxt_last = 1'b1;
            end
        end
    end

    // NOTE: state and outputs are registers updated with non-blocking
    // assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state            <= IDLE;
            gen_done         <= 1'b0;
            arb.arb_out_rts  <= 1'b0;
            arb.arb_out_wben <= '0;
            arb.arb_out_addr <= '0;
            arb.arb_out_data <= '0;
            arb.arb_out_op   <= 1'b0;
            hgt_q            <= '0;
            wid_q            <= '0;
            lane_q           <= '0;
            color_q          <= '0;
            outline_q        <= 1'b0;
            nw_q             <= '0;
            row_q            <= '0;
            word_q           <= '0;
            ch_q             <= '0;
            row_base_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gen_start_strobe) begin
                        hgt_q      <= cmd_data_hgt;
                        wid_q      <= cmd_data_wid;
                        lane_q     <= init_lane;
                        color_q    <= cmd_data_color;
                        outline_q  <= start_outline;
                        nw_q       <= start_nw;
                        row_q      <= '0;
                        word_q     <= '0;
                        ch_q       <= '0;
                        row_base_q <= init_addr;
                        if (start_empty) begin
                            state    <= DONE;
                            gen_done <= 1'b1;
                        end else begin
                            // Row 0 is never interior, so the first word uses solid enables
                            state            <= DRIVE;
                            arb.arb_out_rts  <= 1'b1;
                            arb.arb_out_op   <= 1'b1;
                            arb.arb_out_addr <= init_addr;
                            arb.arb_out_data <= lane_data(cmd_data_color, '0);
                            arb.arb_out_wben <= calc_wben(17'd0, init_lane, cmd_data_wid, 1'b0);
                        end
                    end
                end
                DRIVE: begin
                    if (xfc) begin
                        if (nxt_last) begin
                            state            <= DONE;
                            gen_done         <= 1'b1;
                            arb.arb_out_rts  <= 1'b0;
                            arb.arb_out_op   <= 1'b0;
                            arb.arb_out_wben <= '0;
                        end else begin
                            ch_q             <= nxt_ch;
                            word_q           <= nxt_word;
                            row_q            <= nxt_row;
                            row_base_q       <= nxt_row_base;
                            arb.arb_out_addr <= nxt_addr;
                            arb.arb_out_data <= lane_data(color_q, nxt_ch);
                            arb.arb_out_wben <= calc_wben(nxt_word, lane_q, wid_q, nxt_interior);
                        end
                    end
                end
                DONE: begin
                    gen_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RECT_GEN_XFER_CNT_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            xfer_cnt <= '0;
        end else if ((state == IDLE) && gen_start_strobe) begin
            xfer_cnt <= '0;
        end else if (xfc && (xfer_cnt != 32'hFFFF_FFFF)) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rect_fill_gen_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_fill_gen_engine
//
// Directed bench for rect_fill_gen_engine (DATA_W=32, NUM_CH=3,
// ROW_STRIDE=240). Inputs change and outputs are sampled on the falling edge.
// Define RECT_GEN_XFER_CNT_EN to also cover the transfer counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rect_fill_gen_engine;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        gen_start_strobe = 1'b0;
    logic [15:0] init_addr = '0;
    logic [1:0]  init_lane = '0;
    logic [15:0] cmd_data_hgt = '0;
    logic [15:0] cmd_data_wid = '0;
    logic [23:0] cmd_data_color = '0;
    logic        cmd_mode = 1'b0;
    logic        data_gen_is_idle;
    logic        gen_done;
`ifdef RECT_GEN_XFER_CNT_EN
    logic [31:0] xfer_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int xfc_n = 0;
    int xfc_mark;

    localparam logic [23:0] COL = 24'h33_22_11;

    // Outline walk (lane 0, wid 9, hgt 3): word-group base address and enables
    logic [15:0] ol_addr [8] = '{16'h0100, 16'h0103, 16'h0106,
                                 16'h01F0, 16'h01F6,
                                 16'h02E0, 16'h02E3, 16'h02E6};
    logic [3:0]  ol_wben [8] = '{4'hF, 4'hF, 4'h1,
                                 4'h1, 4'h1,
                                 4'hF, 4'hF, 4'h1};

    rect_fill_gen_engine_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    rect_fill_gen_engine #(
        .ADDR_W(16), .DATA_W(32), .NUM_CH(3), .ROW_STRIDE(240), .LANE_W(2)
    ) dut (
        .clk              (clk),
        .rst_             (rst_),
        .gen_start_strobe (gen_start_strobe),
        .init_addr        (init_addr),
        .init_lane        (init_lane),
        .cmd_data_hgt     (cmd_data_hgt),
        .cmd_data_wid     (cmd_data_wid),
        .cmd_data_color   (cmd_data_color),
        .cmd_mode         (cmd_mode),
        .data_gen_is_idle (data_gen_is_idle),
        .gen_done         (gen_done),
        .arb              (bus)
`ifdef RECT_GEN_XFER_CNT_EN
        ,
        .xfer_cnt         (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_ && bus.arb_out_rts && bus.arb_in_rtr) xfc_n++;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] rep(input logic [23:0] col, input int ch);
        logic [7:0] b;
        b = col[ch*8 +: 8];
        return {4{b}};
    endfunction

    // Called on a falling edge; returns one falling edge later.
    task automatic start_cmd(input logic [15:0] a, input logic [1:0] lane, input logic [15:0] h,
                             input logic [15:0] w, input logic [23:0] col, input logic mode);
        init_addr        = a;
        init_lane        = lane;
        cmd_data_hgt     = h;
        cmd_data_wid     = w;
        cmd_data_color   = col;
        cmd_mode         = mode;
        gen_start_strobe = 1'b1;
        @(negedge clk);
        gen_start_strobe = 1'b0;
    endtask

    // Waits (bounded) for a presented write with ready high, checks it, then
    // lets it transfer.
    task automatic exp_wr(input string tag, input logic [15:0] a, input logic [31:0] d, input logic [3:0] w);
        for (int i = 0; i < 16 && !(bus.arb_out_rts && bus.arb_in_rtr); i++) @(negedge clk);
        check({tag, ".rts"},  bus.arb_out_rts,  1'b1);
        check({tag, ".addr"}, bus.arb_out_addr, a);
        check({tag, ".data"}, bus.arb_out_data, d);
        check({tag, ".wben"}, bus.arb_out_wben, w);
        check({tag, ".op"},   bus.arb_out_op,   1'b1);
        @(negedge clk);
    endtask

    // Cycle right after the last transfer is the DONE cycle, then idle.
    task automatic exp_done(input string tag);
        check({tag, ".done_rts"},  bus.arb_out_rts,  1'b0);
        check({tag, ".done_wben"}, bus.arb_out_wben, 4'h0);
        check({tag, ".done"},      gen_done,         1'b1);
        check({tag, ".done_idle"}, data_gen_is_idle, 1'b0);
        @(negedge clk);
        check({tag, ".post_done"}, gen_done,         1'b0);
        check({tag, ".post_idle"}, data_gen_is_idle, 1'b1);
    endtask

    initial begin
        bus.arb_in_rtr = 1'b1;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst.rts",  bus.arb_out_rts,  1'b0);
        check("rst.wben", bus.arb_out_wben, 4'h0);
        check("rst.addr", bus.arb_out_addr, 16'h0);
        check("rst.data", bus.arb_out_data, 32'h0);
        check("rst.op",   bus.arb_out_op,   1'b0);
        check("rst.done", gen_done,         1'b0);
        check("rst.idle", data_gen_is_idle, 1'b1);
        rst_ = 1'b1;
        @(negedge clk);

        // ---- test 1: solid 4x2, aligned ----
        xfc_mark = xfc_n;
        start_cmd(16'h0100, 2'd0, 16'd2, 16'd4, COL, 1'b0);
        check("t1.busy", data_gen_is_idle, 1'b0);
        for (int r = 0; r < 2; r++)
            for (int ch = 0; ch < 3; ch++)
                exp_wr($sformatf("t1.r%0d.c%0d", r, ch), 16'(16'h0100 + r * 240 + ch), rep(COL, ch), 4'hF);
        exp_done("t1");
        check("t1.count", xfc_n - xfc_mark, 6);
`ifdef RECT_GEN_XFER_CNT_EN
        check("t1.xfer_cnt", xfer_cnt, 32'd6);
`endif

        // ---- test 2: backpressure on the 2nd write + ignored strobe ----
        xfc_mark = xfc_n;
        start_cmd(16'h0100, 2'd0, 16'd2, 16'd4, COL, 1'b0);
        exp_wr("t2.w0", 16'h0100, 32'h11111111, 4'hF);
        bus.arb_in_rtr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // Strobe with a different command while driving
                cmd_data_wid     = 16'd0;
                cmd_data_color   = 24'hAA_AA_AA;
                init_addr        = 16'h0400;
                gen_start_strobe = 1'b1;
            end else begin
                gen_start_strobe = 1'b0;
            end
            check($sformatf("t2.hold%0d.rts", i),  bus.arb_out_rts,  1'b1);
            check($sformatf("t2.hold%0d.addr", i), bus.arb_out_addr, 16'h0101);
            check($sformatf("t2.hold%0d.data", i), bus.arb_out_data, 32'h22222222);
            check($sformatf("t2.hold%0d.wben", i), bus.arb_out_wben, 4'hF);
        end
        gen_start_strobe = 1'b0;
        check("t2.hold_count", xfc_n - xfc_mark, 1);
        bus.arb_in_rtr = 1'b1;
        exp_wr("t2.w1", 16'h0101, 32'h22222222, 4'hF);
        exp_wr("t2.w2", 16'h0102, 32'h33333333, 4'hF);
        exp_wr("t2.w3", 16'h01F0, 32'h11111111, 4'hF);
        exp_wr("t2.w4", 16'h01F1, 32'h22222222, 4'hF);
        exp_wr("t2.w5", 16'h01F2, 32'h33333333, 4'hF);
        exp_done("t2");
        check("t2.count", xfc_n - xfc_mark, 6);
`ifdef RECT_GEN_XFER_CNT_EN
        check("t2.xfer_cnt", xfer_cnt, 32'd6);
`endif

        // ---- test 3: unaligned, lane 3, wid 2, hgt 1 ----
        xfc_mark = xfc_n;
        start_cmd(16'h0100, 2'd3, 16'd1, 16'd2, COL, 1'b0);
        for (int ch = 0; ch < 3; ch++)
            exp_wr($sformatf("t3.w0.c%0d", ch), 16'(16'h0100 + ch), rep(COL, ch), 4'b1000);
        for (int ch = 0; ch < 3; ch++)
            exp_wr($sformatf("t3.w1.c%0d", ch), 16'(16'h0103 + ch), rep(COL, ch), 4'b0001);
        exp_done("t3");
        check("t3.count", xfc_n - xfc_mark, 6);

        // ---- test 4: outline, lane 0, wid 9, hgt 3 ----
        xfc_mark = xfc_n;
        start_cmd(16'h0100, 2'd0, 16'd3, 16'd9, COL, 1'b1);
        for (int g = 0; g < 8; g++)
            for (int ch = 0; ch < 3; ch++)
                exp_wr($sformatf("t4.g%0d.c%0d", g, ch), 16'(ol_addr[g] + 16'(ch)), rep(COL, ch), ol_wben[g]);
        exp_done("t4");
        check("t4.count", xfc_n - xfc_mark, 24);
`ifdef RECT_GEN_XFER_CNT_EN
        check("t4.xfer_cnt", xfer_cnt, 32'd24);
`endif

        // ---- test 5: wid 0 -> straight to DONE ----
        xfc_mark = xfc_n;
        start_cmd(16'h0100, 2'd0, 16'd2, 16'd0, COL, 1'b0);
        check("t5.rts",  bus.arb_out_rts, 1'b0);
        check("t5.done", gen_done,        1'b1);
        @(negedge clk);
        check("t5.post_done", gen_done,         1'b0);
        check("t5.post_idle", data_gen_is_idle, 1'b1);
        check("t5.count", xfc_n - xfc_mark, 0);
`ifdef RECT_GEN_XFER_CNT_EN
        check("t5.xfer_cnt", xfer_cnt, 32'd0);
`endif

        // ---- test 6: reset in the middle of row 1 ----
        xfc_mark = xfc_n;
        start_cmd(16'h0100, 2'd0, 16'd2, 16'd4, COL, 1'b0);
        exp_wr("t6.w0", 16'h0100, 32'h11111111, 4'hF);
        exp_wr("t6.w1", 16'h0101, 32'h22222222, 4'hF);
        exp_wr("t6.w2", 16'h0102, 32'h33333333, 4'hF);
        exp_wr("t6.w3", 16'h01F0, 32'h11111111, 4'hF);
        rst_ = 1'b0;
        #1;
        check("t6.rst_rts",  bus.arb_out_rts,  1'b0);
        check("t6.rst_wben", bus.arb_out_wben, 4'h0);
        check("t6.rst_addr", bus.arb_out_addr, 16'h0);
        check("t6.rst_data", bus.arb_out_data, 32'h0);
        check("t6.rst_op",   bus.arb_out_op,   1'b0);
        check("t6.rst_done", gen_done,         1'b0);
        check("t6.rst_idle", data_gen_is_idle, 1'b1);
`ifdef RECT_GEN_XFER_CNT_EN
        check("t6.rst_xfer_cnt", xfer_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_ = 1'b1;
        repeat (10) @(negedge clk);
        check("t6.after_rts",  bus.arb_out_rts,  1'b0);
        check("t6.after_idle", data_gen_is_idle, 1'b1);
        check("t6.count", xfc_n - xfc_mark, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
